// File: rtl/ex_alu_seq.sv
// ex_alu_seq: execute-stage ALU for the RV32I pipeline.
// Single-cycle add/sub/logic/compare; shifts iterate one bit per cycle
// and hold busy high so the hazard unit stalls the front end.
module ex_alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [3:0]      ALUCtrl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            done,
  output logic            busy
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q;
  logic [4:0]      cnt_q;
  alu_op_e         op_q;

  logic [4:0]      shamt;
  logic            is_shift;
  logic            accept;
  logic            launch_shift;
  logic [XLEN-1:0] single_result;
  logic [XLEN-1:0] shifted_acc;

  assign shamt        = SrcB[4:0];
  assign is_shift     = (ALUCtrl == OP_SLL) || (ALUCtrl == OP_SRL) || (ALUCtrl == OP_SRA);
  assign accept       = (state_q == IDLE) && start && !flush;
  assign launch_shift = accept && is_shift && (shamt != 5'd0);
  assign Zero         = (ALUResult == '0);

  // State register: reset and flush both land in IDLE via state_d/rst.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: enter SHIFT for non-zero shifts, leave on last step or flush.
  always_comb begin
    // NOTE: default assignment first so no latch is inferred on unlisted paths.
    state_d = state_q;
    case (state_q)
      IDLE:  if (launch_shift) state_d = SHIFT;
      SHIFT: if (flush || (cnt_q == 5'd1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: stall request is simply "in the iterative shift".
  always_comb begin
    busy = (state_q == SHIFT);
  end

  // Single-cycle result; a zero-amount shift passes SrcA straight through.
  always_comb begin
    single_result = '0;
    case (ALUCtrl)
      OP_ADD:  single_result = SrcA + SrcB;
      OP_SUB:  single_result = SrcA - SrcB;
      OP_AND:  single_result = SrcA & SrcB;
      OP_OR:   single_result = SrcA | SrcB;
      OP_XOR:  single_result = SrcA ^ SrcB;
      OP_SLT:  single_result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: single_result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL, OP_SRL, OP_SRA: single_result = SrcA;
      default: single_result = '0;
    endcase
  end

  // One-bit step of the iterative shifter for the latched shift op.
  always_comb begin
    shifted_acc = acc_q;
    case (op_q)
      OP_SLL:  shifted_acc = {acc_q[XLEN-2:0], 1'b0};
      OP_SRL:  shifted_acc = {1'b0, acc_q[XLEN-1:1]};
      default: shifted_acc = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end

  // Datapath: load/step the shifter, register results and pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= OP_ADD;
      ALUResult <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          if (launch_shift) begin
            acc_q <= SrcA;
            cnt_q <= shamt;
            op_q  <= alu_op_e'(ALUCtrl);
          end else begin
            ALUResult <= single_result;
            done      <= 1'b1;
          end
        end
      end else if (!flush) begin
        acc_q <= shifted_acc;
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          ALUResult <= shifted_acc;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_seq.sv
// Self-checking bench for ex_alu_seq: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_ex_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [3:0]  ALUCtrl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        done;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_result;

  ex_alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .ALUCtrl(ALUCtrl),
    .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult), .Zero(Zero),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result from whole-word arithmetic, barrel shifts included.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << n;
      4'd8: return a >> n;
      4'd9: return $unsigned($signed(a) >>> n);
      default: return 32'd0;
    endcase
  endfunction

  // Reference: extra cycles beyond a single-cycle op equal the shift amount.
  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd7 && op <= 4'd9) return int'(b[4:0]);
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op and follow it to completion; poke drives an add while busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    logic [31:0] exp;
    int          lat;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, b);
    ALUCtrl = op; SrcA = a; SrcB = b; start = 1'b1;
    tick();
    if (poke && lat > 1) begin
      ALUCtrl = 4'd0; SrcA = $urandom; SrcB = $urandom;
    end else begin
      start = 1'b0;
    end
    for (int k = 0; k < lat; k++) begin
      check("busy_during_op", {31'd0, busy}, 32'd1);
      check("done_early", {31'd0, done}, 32'd0);
      if (k == lat - 1) start = 1'b0;
      tick();
    end
    start = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("result", ALUResult, exp);
    check("zero_flag", {31'd0, Zero}, {31'd0, (exp == 32'd0)});
    last_result = exp;
    tick();
    check("done_single", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    ALUCtrl = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
    tick(); tick();
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    last_result = 32'd0;

    // Directed corner cases
    run_op(4'd0, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_op(4'd5, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_op(4'd6, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_op(4'd1, 32'hFFFFFFFF, 32'd1, 1'b0);
    run_op(4'd9, 32'h80000000, 32'd4, 1'b1);
    run_op(4'd7, 32'h00001234, 32'h20, 1'b0);
    run_op(4'd0, 32'd5, 32'd9, 1'b0);
    run_op(4'd12, 32'hDEADBEEF, 32'h1234, 1'b0);

    // Flush on the 10th busy cycle of srl by 31
    run_op(4'd3, 32'h00A0_0000, 32'h0000_0055, 1'b0);
    ALUCtrl = 4'd8; SrcA = 32'hFFFFFFFF; SrcB = 32'd31; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("flush_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    check("flush_busy10", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_drop", {31'd0, busy}, 32'd0);
    check("flush_no_done", {31'd0, done}, 32'd0);
    check("flush_hold", ALUResult, last_result);
    for (int k = 0; k < 25; k++) begin
      check("flush_quiet", {31'd0, done}, 32'd0);
      tick();
    end
    run_op(4'd4, 32'h0F0F0F0F, 32'hFF00FF00, 1'b0);

    // Flush and start together in IDLE: op dropped
    ALUCtrl = 4'd0; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_done", {31'd0, done}, 32'd0);
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    check("flush_start_hold", ALUResult, last_result);

    // Back-to-back: new start accepted in the done cycle
    ALUCtrl = 4'd0; SrcA = 32'd5; SrcB = 32'd7; start = 1'b1;
    tick();
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first", ALUResult, 32'd12);
    ALUCtrl = 4'd1;
    tick();
    start = 1'b0;
    check("b2b_second_done", {31'd0, done}, 32'd1);
    check("b2b_second", ALUResult, 32'hFFFFFFFE);
    tick();
    check("b2b_quiet", {31'd0, done}, 32'd0);
    last_result = 32'hFFFFFFFE;

    // Reset on busy cycle 5 of sll by 20
    ALUCtrl = 4'd7; SrcA = 32'h0000_0ABC; SrcB = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_result", ALUResult, 32'd0);
    check("rst_mid_zero", {31'd0, Zero}, 32'd1);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_busy_clr", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      check("rst_mid_quiet", {30'd0, busy, done}, 32'd0);
      tick();
    end
    last_result = 32'd0;

    // Randomized operations, occasionally poking start while busy
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'd0;
      if ($urandom_range(0, 3) == 0) b = a;
      run_op(op, a, b, ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_alu_seq.md
# ex_alu_seq

Execute-stage arithmetic unit of the pipelined RV32I core. It sits directly downstream of the ALU control decoder and consumes its 4-bit `ALUCtrl` operation code together with the forwarded operands from the ID/EX register. Add, subtract, logic and compare operations complete in one registered cycle. Shifts run on an area-saving iterative shifter, one bit per cycle, and raise `busy` so the hazard unit stalls IF/ID/EX.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; shift amount taken from `SrcB[4:0]`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  operation valid from ID/EX; sampled only when idle.
- `flush`  in  1  synchronous abort from the hazard unit (branch mispredict/kill).
- `ALUCtrl`  in  4  operation code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra; 10–15 are undefined.
- `SrcA`  in  XLEN  operand A.
- `SrcB`  in  XLEN  operand B; for shifts only bits [4:0] are used.
- `ALUResult`  out  XLEN  registered result; holds its value until the next completion.
- `Zero`  out  1  combinational `ALUResult == 0`; used for beq/bne resolution.
- `done`  out  1  one-cycle pulse; `ALUResult` is new this cycle.
- `busy`  out  1  stall request; high while a multi-cycle shift is in progress.

## Operation
- States: IDLE, SHIFT.
- IDLE with `start`=1 and `flush`=0, non-shift op (codes 0–6, 10–15):
  - Compute the result and register it into `ALUResult`.
  - `done`=1 in the next cycle; the state stays IDLE.
- Arithmetic rules:
  - add/sub wrap modulo 2^32; there is no overflow flag.
  - slt is a signed two's-complement compare; sltu is unsigned. Both return 32'd0 or 32'd1.
  - Undefined codes return 32'd0.
- IDLE with `start`, shift op (codes 7–9), `SrcB[4:0]` = 0:
  - Treated as single-cycle: `ALUResult`=`SrcA`, then `done`.
- IDLE with `start`, shift op, `SrcB[4:0]` = n > 0:
  - Load `acc`←`SrcA` and `cnt`←n, latch the op, and go to SHIFT.
- SHIFT, each cycle:
  - Shift `acc` by 1: sll inserts 0 at the LSB, srl inserts 0 at the MSB, sra replicates bit 31.
  - `cnt` decrements by 1.
  - On the edge where `cnt` goes 1→0, write the shifted `acc` to `ALUResult`, pulse `done`, and return to IDLE.
- `busy` = (state == SHIFT), decoded combinationally from the state register.
- `start` while in SHIFT is ignored. The upstream stage is stalled by `busy` and re-presents the instruction.
- `flush`:
  - In any state, next state is IDLE and no `done` is produced for the aborted op.
  - `ALUResult` keeps its prior value.
  - `flush` and `start` in the same cycle: `flush` wins and the op is dropped.
- `rst` overrides everything: state IDLE, `ALUResult`=0, `done`=0, `busy`=0, `cnt`=0, `acc`=0.

## Timing
- Reset values: `ALUResult`=32'h0, `Zero`=1, `done`=0, `busy`=0.
- Single-cycle op latency:
  - `start` sampled at edge E0.
  - `ALUResult` valid and `done`=1 during the cycle after E0, i.e. 1 cycle.
- Shift by n>0:
  - `busy`=1 from after E0 until after En.
  - `ALUResult`/`done` appear after edge En, i.e. n cycles after a single-cycle op would complete.
- Back-to-back: a new `start` is accepted in the cycle `done` is high, because the state is already IDLE.
- `done` never stays high for more than one cycle for a single operation.

## Test plan
- Wrap-around add: `ALUCtrl`=0, `SrcA`=32'hFFFFFFFF, `SrcB`=1 → one cycle later `ALUResult`=0, `Zero`=1, `done` pulses once, `busy` never asserted.
- Signed vs. unsigned compare:
  - `SrcA`=32'hFFFFFFFF, `SrcB`=1, `ALUCtrl`=5 (slt) → 1.
  - Same operands, `ALUCtrl`=6 (sltu) → 0.
  - Same operands, `ALUCtrl`=1 (sub) → 32'hFFFFFFFE, `Zero`=0.
- Arithmetic shift: `ALUCtrl`=9, `SrcA`=32'h80000000, `SrcB`=4 → `busy` high for exactly 4 cycles; `done` and `ALUResult`=32'hF8000000 arrive 4 cycles after a single-cycle op would. A `start` with `ALUCtrl`=0 applied while busy is ignored.
- Zero-amount shift and undefined code:
  - `ALUCtrl`=7, `SrcB`=32'h20 (low bits 0), `SrcA`=32'h1234 → 32'h1234 in 1 cycle, no `busy`.
  - `ALUCtrl`=12 → `ALUResult`=0, `Zero`=1.
- Flush mid-shift: srl of 32'hFFFFFFFF by 31, `flush` asserted on the 10th busy cycle → `busy` drops the next cycle, no `done`, `ALUResult` holds its previous value. A `start` in the following cycle completes normally.
- Reset mid-shift: sll by 20 with `rst` asserted on busy cycle 5 → all outputs return to their reset values the next cycle, and no `done` follows.
